led7_scan: RTL and testbench

LED7_SCAN -- requirements
Module: led7_scan

---
 rtl/led7_scan.sv | 110 +++++++++++
 tb/tb_led7_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led7_scan.sv
// rtl/led7_scan.sv - six-digit multiplexed 7-segment scanner with frame-shadowed BCD inputs
// Optional feature: define LED7_LZB_EN to blank a leading zero in the hours tens digit.
module led7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_unit,
  input  logic [3:0] hr_tens,
  input  logic       colon,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] sh_q, sh_d;
  logic            col_q, col_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      an_q, an_d;
  logic            tick;
  logic            blank;
  logic [3:0]      digit;

  assign tick = (cnt_q == 16'(SCAN_DIV - 1));

  // A zero-length blank window would make the compare constant, so it is removed outright.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt_q < 16'(BLANK_CYC));
    end
  endgenerate

  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q;
    sh_d  = sh_q;
    col_d = col_q;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      if (idx_q == 3'd5) begin
        sh_d  = {hr_tens, hr_unit, min_tens, min_unit, sec_tens, sec_unit};
        col_d = colon;
      end
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    digit = sh_q[0];
      3'd1:    digit = sh_q[1];
      3'd2:    digit = sh_q[2];
      3'd3:    digit = sh_q[3];
      3'd4:    digit = sh_q[4];
      default: digit = sh_q[5];
    endcase
    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
`ifdef LED7_LZB_EN
    if (idx_q == 3'd5 && digit == 4'd0) seg_d = 7'b1111111;
`endif
    dp_d = ~(col_q && (idx_q == 3'd2 || idx_q == 3'd4));
    an_d = blank ? 6'b111111 : ~(6'b000001 << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      idx_q <= 3'd0;
      sh_q  <= '0;
      col_q <= 1'b0;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
      an_q  <= 6'b111111;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      col_q <= col_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_led7_scan.sv
// tb/tb_led7_scan.sv - randomized bench for led7_scan against a frame-level display model
module tb_led7_scan;

  localparam int D = 4;
  localparam int BL0 = 1;
  localparam int BL1 = 2;
  localparam int BL2 = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [5:0][3:0] din;
  logic            colon;
  logic [6:0]      seg_a, seg_b, seg_c;
  logic            dp_a, dp_b, dp_c;
  logic [5:0]      an_a, an_b, an_c;

  led7_scan #(.SCAN_DIV(D), .BLANK_CYC(BL0)) dut_a (
    .clk(clk), .rst(rst),
    .sec_unit(din[0]), .sec_tens(din[1]), .min_unit(din[2]),
    .min_tens(din[3]), .hr_unit(din[4]), .hr_tens(din[5]),
    .colon(colon), .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  led7_scan #(.SCAN_DIV(D), .BLANK_CYC(BL1)) dut_b (
    .clk(clk), .rst(rst),
    .sec_unit(din[0]), .sec_tens(din[1]), .min_unit(din[2]),
    .min_tens(din[3]), .hr_unit(din[4]), .hr_tens(din[5]),
    .colon(colon), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  led7_scan #(.SCAN_DIV(D), .BLANK_CYC(BL2)) dut_c (
    .clk(clk), .rst(rst),
    .sec_unit(din[0]), .sec_tens(din[1]), .min_unit(din[2]),
    .min_tens(din[3]), .hr_unit(din[4]), .hr_tens(din[5]),
    .colon(colon), .seg(seg_c), .dp(dp_c), .an(an_c)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: the displayed frame and the number of clock edges since reset release.
  logic [5:0][3:0] m_sh;
  logic            m_col;
  int              k;
  logic [6:0]      e_seg;
  logic            e_dp;
  logic [5:0]      e_an0, e_an1, e_an2;

  function automatic logic [6:0] seg_of(input logic [3:0] d, input int slot);
    logic [6:0] r;
    case (d)
      4'd0: r = 7'b1000000;  4'd1: r = 7'b1111001;
      4'd2: r = 7'b0100100;  4'd3: r = 7'b0110000;
      4'd4: r = 7'b0011001;  4'd5: r = 7'b0010010;
      4'd6: r = 7'b0000010;  4'd7: r = 7'b1111000;
      4'd8: r = 7'b0000000;  4'd9: r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
`ifdef LED7_LZB_EN
    if (slot == 5 && d == 4'd0) r = 7'b1111111;
`endif
    return r;
  endfunction

  function automatic logic [5:0] an_of(input int cnt, input int idx, input int bl);
    logic [5:0] r;
    r = 6'b111111;
    if (cnt >= bl) r[idx] = 1'b0;
    return r;
  endfunction

  task automatic step_model();
    int cnt, idx;
    cnt   = k % D;
    idx   = (k / D) % 6;
    e_seg = seg_of(m_sh[idx], idx);
    e_dp  = !(m_col && (idx == 2 || idx == 4));
    e_an0 = an_of(cnt, idx, BL0);
    e_an1 = an_of(cnt, idx, BL1);
    e_an2 = an_of(cnt, idx, BL2);
    if (cnt == D - 1 && idx == 5) begin
      m_sh  = din;
      m_col = colon;
    end
    k++;
  endtask

  task automatic model_reset();
    k     = 0;
    m_sh  = '0;
    m_col = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg_a"}, {1'b0, seg_a}, 8'h7f);
    check({tag, "_seg_b"}, {1'b0, seg_b}, 8'h7f);
    check({tag, "_seg_c"}, {1'b0, seg_c}, 8'h7f);
    check({tag, "_dp"},    {5'b0, dp_a, dp_b, dp_c}, 8'h07);
    check({tag, "_an_a"},  {2'b0, an_a}, 8'h3f);
    check({tag, "_an_b"},  {2'b0, an_b}, 8'h3f);
    check({tag, "_an_c"},  {2'b0, an_c}, 8'h3f);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 5; i++)
      if ($urandom_range(0, 7) == 0) din[i] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) din[5] = 4'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) colon = ~colon;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      step_model();
      @(negedge clk);
      check("seg_a", {1'b0, seg_a}, {1'b0, e_seg});
      check("seg_b", {1'b0, seg_b}, {1'b0, e_seg});
      check("seg_c", {1'b0, seg_c}, {1'b0, e_seg});
      check("dp_a",  {7'b0, dp_a}, {7'b0, e_dp});
      check("dp_c",  {7'b0, dp_c}, {7'b0, e_dp});
      check("an_a",  {2'b0, an_a}, {2'b0, e_an0});
      check("an_b",  {2'b0, an_b}, {2'b0, e_an1});
      check("an_c",  {2'b0, an_c}, {2'b0, e_an2});
      if (rnd) randomize_inputs();
    end
  endtask

  initial begin
    din   = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    colon = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_reset("rst_hold");
    end
    rst = 1'b0;
    run_cycles(6 * D * 3, 1'b0);
    run_cycles(300, 1'b1);

    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    check_reset("rst_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    din[5] = 4'd0;
    run_cycles(200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
